// File: rtl/spi_reader_pkg.sv
// Shared defaults for the SPI reader and the consumers of its data/address bus.
package spi_reader_pkg;

  localparam int DEF_WORD_WIDTH   = 16;
  localparam int DEF_ADDR_WIDTH   = 11;
  localparam int DEF_IDLE_TIMEOUT = 1024;

endpackage

// File: rtl/spi_reader_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; clears with the system reset.
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/spi_reader.sv
// Oversampling SPI word receiver: collects MSB-first words, strobes data with a
// per-frame word index, and forwards the synchronized stream to the next device.
module spi_reader
  import spi_reader_pkg::*;
#(
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  din,
  input  logic                  cin,
  output logic                  dout,
  output logic                  cout,
  output logic [WORD_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  readStrobe
);

  localparam int BIT_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BIT_W-1:0]      BIT_LAST   = BIT_W'(WORD_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;
  localparam logic [IDLE_W-1:0]     IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0]     IDLE_PRE   = IDLE_W'(IDLE_TIMEOUT - 1);

  logic w_din_s;
  logic w_cin_s;
  logic w_edge;
  logic w_timeout;
  logic [WORD_WIDTH-1:0] w_word;

  logic                  r_cin_prev;
  logic [WORD_WIDTH-2:0] r_shift;
  logic [BIT_W-1:0]      r_bit;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [IDLE_W-1:0]     r_idle;
  logic [WORD_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_strobe;

  sync2 u_sync_din (.clock(clock), .reset(reset), .i_d(din), .o_q(w_din_s));
  sync2 u_sync_cin (.clock(clock), .reset(reset), .i_d(cin), .o_q(w_cin_s));

  assign w_edge = w_cin_s & ~r_cin_prev;
  // Fires on the low sample that brings the idle count up to the limit; the
  // count then parks there, so the first high sample afterwards is never masked.
  assign w_timeout = ~w_cin_s & (r_idle == IDLE_PRE);
  // The shift register keeps only the earlier bits; the incoming bit completes the word.
  assign w_word = {r_shift, w_din_s};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cin_prev <= 1'b0;
      r_shift    <= '0;
      r_bit      <= '0;
      r_index    <= '0;
      r_idle     <= '0;
      r_data     <= '0;
      r_addr     <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_cin_prev <= w_cin_s;
      r_strobe   <= 1'b0;

      if (w_cin_s) begin
        r_idle <= '0;
      end else if (r_idle != IDLE_LIMIT) begin
        r_idle <= r_idle + 1'b1;
      end

      if (w_timeout) begin
        r_bit   <= '0;
        r_index <= '0;
      end else if (w_edge) begin
        r_shift <= w_word[WORD_WIDTH-2:0];
        if (r_bit == BIT_LAST) begin
          r_bit    <= '0;
          r_data   <= w_word;
          r_addr   <= r_index;
          r_strobe <= 1'b1;
          if (r_index != ADDR_MAX) begin
            r_index <= r_index + 1'b1;
          end
        end else begin
          r_bit <= r_bit + 1'b1;
        end
      end
    end
  end

  assign data       = r_data;
  assign address    = r_addr;
  assign readStrobe = r_strobe;
  assign dout       = w_din_s;
  assign cout       = w_cin_s;

endmodule

// File: tb/tb_spi_reader.sv
// Scoreboard bench for spi_reader: default instance plus a narrow instance for index saturation.
module tb_spi_reader;
  import spi_reader_pkg::*;

  localparam int WW  = DEF_WORD_WIDTH;
  localparam int AW  = DEF_ADDR_WIDTH;
  localparam int IT  = DEF_IDLE_TIMEOUT;
  localparam int WW2 = 4;
  localparam int AW2 = 2;
  localparam int IT2 = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic din   = 1'b0;
  logic cin   = 1'b0;
  logic din2  = 1'b0;
  logic cin2  = 1'b0;

  logic          dout, cout, readStrobe;
  logic [WW-1:0] data;
  logic [AW-1:0] address;
  logic           dout2, cout2, readStrobe2;
  logic [WW2-1:0] data2;
  logic [AW2-1:0] address2;

  always #5 clock = ~clock;

  spi_reader dut (
    .clock(clock), .reset(reset), .din(din), .cin(cin),
    .dout(dout), .cout(cout), .data(data), .address(address), .readStrobe(readStrobe)
  );

  spi_reader #(.WORD_WIDTH(WW2), .ADDR_WIDTH(AW2), .IDLE_TIMEOUT(IT2)) dut2 (
    .clock(clock), .reset(reset), .din(din2), .cin(cin2),
    .dout(dout2), .cout(cout2), .data(data2), .address(address2), .readStrobe(readStrobe2)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int strobes1 = 0;
  int strobes2 = 0;
  bit sb_en = 1'b1;

  logic [AW+WW-1:0]   q1[$];
  logic [AW2+WW2-1:0] q2[$];
  logic [AW+WW-1:0]   e1;
  logic [AW2+WW2-1:0] e2;

  always @(negedge clock) begin
    if (reset && readStrobe) begin
      strobes1++;
      if (sb_en) begin
        n_chk++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL sb1_unexpected got addr=%0d data=%h, no strobe expected", address, data);
        end else begin
          e1 = q1.pop_front();
          if ({address, data} !== e1) begin
            n_fail++;
            $display("FAIL sb1_word got addr=%0d data=%h expected addr=%0d data=%h",
                     address, data, e1[AW+WW-1:WW], e1[WW-1:0]);
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset && readStrobe2) begin
      strobes2++;
      n_chk++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL sb2_unexpected got addr=%0d data=%h, no strobe expected", address2, data2);
      end else begin
        e2 = q2.pop_front();
        if ({address2, data2} !== e2) begin
          n_fail++;
          $display("FAIL sb2_word got addr=%0d data=%h expected addr=%0d data=%h",
                   address2, data2, e2[AW2+WW2-1:WW2], e2[WW2-1:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din = b; cin = 1'b0; tick(3);
    cin = 1'b1; tick(3);
    cin = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    for (int i = WW - 1; i >= 0; i--) send_bit(w[i]);
    tick(2);
  endtask

  task automatic send_bit2(input logic b);
    din2 = b; cin2 = 1'b0; tick(3);
    cin2 = 1'b1; tick(3);
    cin2 = 1'b0;
  endtask

  task automatic send_word2(input logic [WW2-1:0] w);
    for (int i = WW2 - 1; i >= 0; i--) send_bit2(w[i]);
    tick(2);
  endtask

  task automatic idle_gap();
    cin = 1'b0;
    tick(IT + 10);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) tick(1);
    n_chk++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain got %0d/%0d words outstanding, required 0", name, q1.size(), q2.size());
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    tick(2);
    n_chk++;
    if ({data, address, readStrobe, dout, cout} !== '0 ||
        {data2, address2, readStrobe2, dout2, cout2} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got data=%h addr=%0d strb=%b dout=%b cout=%b, required all 0",
               data, address, readStrobe, dout, cout);
    end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    int s;
    idle_gap();
    s = strobes1;
    q1.push_back({AW'(0), 16'hA5C3});
    send_word(16'hA5C3);
    drain("single");
    n_chk++;
    if (strobes1 - s != 1) begin
      n_fail++;
      $display("FAIL single_count got %0d strobes, required 1", strobes1 - s);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    logic [WW-1:0] w [3] = '{16'h0001, 16'h8000, 16'hFFFF};
    idle_gap();
    s = strobes1;
    for (int i = 0; i < 3; i++) q1.push_back({AW'(i), w[i]});
    for (int i = 0; i < 3; i++) send_word(w[i]);
    drain("b2b");
    n_chk++;
    if (strobes1 - s != 3) begin
      n_fail++;
      $display("FAIL b2b_count got %0d strobes, required 3", strobes1 - s);
    end
  endtask

  task automatic test_partial();
    int s;
    logic [7:0] part = 8'hAB;
    idle_gap();
    s = strobes1;
    for (int i = 7; i >= 0; i--) send_bit(part[i]);
    tick(5);
    n_chk++;
    if (strobes1 != s) begin
      n_fail++;
      $display("FAIL partial_nostrobe got %0d strobes, required 0", strobes1 - s);
    end
    cin = 1'b0;
    tick(IT + 10);
    q1.push_back({AW'(0), 16'h1234});
    send_word(16'h1234);
    drain("partial");
    n_chk++;
    if (strobes1 - s != 1) begin
      n_fail++;
      $display("FAIL partial_count got %0d strobes, required 1", strobes1 - s);
    end
  endtask

  task automatic test_frame_restart();
    int s;
    idle_gap();
    s = strobes1;
    q1.push_back({AW'(0), 16'h1111});
    q1.push_back({AW'(1), 16'h2222});
    send_word(16'h1111);
    send_word(16'h2222);
    idle_gap();
    q1.push_back({AW'(0), 16'h3333});
    send_word(16'h3333);
    drain("restart");
    n_chk++;
    if (strobes1 - s != 3) begin
      n_fail++;
      $display("FAIL restart_count got %0d strobes, required 3", strobes1 - s);
    end
  endtask

  task automatic test_reset_mid_word();
    int s;
    logic [4:0] pre = 5'b10110;
    idle_gap();
    for (int i = 4; i >= 0; i--) send_bit(pre[i]);
    din = 1'b1; cin = 1'b1;
    tick(3);
    reset = 1'b0;
    #2;
    n_chk++;
    if ({data, address, readStrobe, dout, cout} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async got data=%h addr=%0d strb=%b dout=%b cout=%b, required all 0",
               data, address, readStrobe, dout, cout);
    end
    tick(3);
    n_chk++;
    if ({data, address, readStrobe, dout, cout} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_held got data=%h addr=%0d strb=%b dout=%b cout=%b, required all 0",
               data, address, readStrobe, dout, cout);
    end
    cin = 1'b0; din = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
    s = strobes1;
    q1.push_back({AW'(0), 16'h00FF});
    send_word(16'h00FF);
    drain("rstmid");
    n_chk++;
    if (strobes1 - s != 1) begin
      n_fail++;
      $display("FAIL rstmid_count got %0d strobes, required 1", strobes1 - s);
    end
  endtask

  task automatic test_saturation();
    int s;
    logic [WW2-1:0] w;
    cin2 = 1'b0;
    tick(IT2 + 10);
    s = strobes2;
    for (int i = 0; i < 6; i++) begin
      w = WW2'(i + 5);
      q2.push_back({AW2'((i > 3) ? 3 : i), w});
      send_word2(w);
    end
    tick(IT2 + 10);
    q2.push_back({AW2'(0), 4'h9});
    send_word2(4'h9);
    drain("sat");
    n_chk++;
    if (strobes2 - s != 7) begin
      n_fail++;
      $display("FAIL sat_count got %0d strobes, required 7", strobes2 - s);
    end
  endtask

  task automatic test_passthrough();
    logic [1:0] hist [200];
    sb_en = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clock); #1;
      hist[n] = 2'($urandom_range(0, 3));
      cin = hist[n][1];
      din = hist[n][0];
      @(negedge clock);
      if (n >= 2) begin
        n_chk++;
        if ({cout, dout} !== hist[n-2]) begin
          n_fail++;
          $display("FAIL passthru_%0d got cout/dout=%b, required %b", n, {cout, dout}, hist[n-2]);
        end
      end
    end
    cin = 1'b0; din = 1'b0;
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion, required finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_partial();
    test_frame_restart();
    test_reset_mid_word();
    test_saturation();
    test_passthrough();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reader.md
SPI_READER -- requirements
Module: spi_reader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, bits per received word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, width of the word address counter.
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 1024, the number of clock cycles with cin held low that ends a frame.
REQ-004 SHALL have port clock, input, 1 bit: the single system clock (48 MHz nominal); all logic is in this domain.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port din, input, 1 bit: asynchronous serial data input.
REQ-007 SHALL have port cin, input, 1 bit: asynchronous serial clock input; data is sampled on its rising edge.
REQ-008 SHALL have port dout, output, 1 bit: serial data forwarded to the next device in the chain.
REQ-009 SHALL have port cout, output, 1 bit: serial clock forwarded to the next device in the chain.
REQ-010 SHALL have port data, output, WORD_WIDTH bits: the last completed word.
REQ-011 SHALL have port address, output, ADDR_WIDTH bits: the index of the completed word within the frame.
REQ-012 SHALL have port readStrobe, output, 1 bit: one-cycle pulse marking data and address as valid.

Function
REQ-013 SHALL synchronize din and cin into the clock domain, each through a 2-flop synchronizer.
REQ-014 SHALL detect a cin rising edge as synchronized cin == 1 with the previous synchronized sample == 0.
REQ-015 SHALL, on each detected edge, shift synchronized din into a WORD_WIDTH shift register, MSB first.
REQ-016 SHALL, on each detected edge, increment a bit counter that runs 0..WORD_WIDTH-1.
REQ-017 SHALL, on the edge that completes a word (bit counter == WORD_WIDTH-1), load the full word into data and the current word index into address on the next clock.
REQ-018 SHALL assert readStrobe high for exactly one clock in that same cycle, then wrap the bit counter to 0.
REQ-019 SHALL increment the word index after each strobe.
REQ-020 SHALL saturate the word index at 2^ADDR_WIDTH-1; words beyond that still strobe with address = max.
REQ-021 SHALL increment an idle counter each clock while synchronized cin is low and clear it on any high sample.
REQ-022 SHALL, when the idle counter reaches IDLE_TIMEOUT, clear the bit counter and the word index (end of frame); a partial word is discarded with no strobe.
REQ-023 SHALL give the idle-timeout clear priority over a simultaneous edge; an edge in that cycle is impossible because cin is low.
REQ-024 SHALL drive cout and dout from the synchronized cin and din (pass-through, 2-clock latency) so chained devices receive the same stream.
REQ-025 SHALL hold data and address between strobes.

Reset
REQ-026 SHALL, while reset == 0, asynchronously clear to 0 all synchronizers, the shift register, the bit counter, the word index and the idle counter.
REQ-027 SHALL, while reset == 0, hold data = 0, address = 0, readStrobe = 0, dout = 0 and cout = 0.
REQ-028 SHALL start in a fresh frame after reset deasserts mid-word; bits shifted before reset are lost.

Structure
REQ-029 SHALL place the default WORD_WIDTH, ADDR_WIDTH and IDLE_TIMEOUT constants in a shared package (spi_reader_pkg) used by both spi_reader and the consumers of the data/address bus.
REQ-030 SHALL implement the 2-flop synchronizer as one reusable sub-module, sync2, instantiated for din and cin.

Verification
REQ-031 SHALL cover: send 16 bits 0xA5C3 MSB-first -> exactly one readStrobe, data = 0xA5C3, address = 0.
REQ-032 SHALL cover: send three words 0x0001, 0x8000, 0xFFFF back-to-back -> strobes with addresses 0, 1, 2 and matching data.
REQ-033 SHALL cover: send 8 bits, hold cin low for IDLE_TIMEOUT+10 clocks, then send 0x1234 -> no strobe for the partial word; one strobe with data = 0x1234, address = 0.
REQ-034 SHALL cover: send 2 words, idle timeout, send 1 word -> third strobe has address = 0.
REQ-035 SHALL cover: assert reset low mid-word (after 5 bits), release it, send 0x00FF -> all outputs 0 during reset; the next strobe has data = 0x00FF, address = 0.
REQ-036 SHALL cover: toggle cin/din with a random pattern -> cout and dout equal cin and din delayed by 2 clocks.
